// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: captures the per-cycle PC / instruction / ALU-result
// stream into a circular buffer. A PC-match or forced trigger ends capture
// POST_TRIG samples later. The buffer is then drained oldest-first through a
// registered valid/ready port.
// Build macro TRACE_TIMESTAMP_EN: adds a free-running TS_W-bit cycle counter
// whose value is stored in the MSBs of every entry.
module cpu_trace_buffer #(
   parameter int PC_W      = 32,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 4,
   parameter int TS_W      = 16,
`ifdef TRACE_TIMESTAMP_EN
   localparam int ENTRY_W  = TS_W + PC_W + 2*DATA_W,
`else
   localparam int ENTRY_W  = PC_W + 2*DATA_W + 0*TS_W,
`endif
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               trace_valid,
   input  logic [PC_W-1:0]    trace_pc,
   input  logic [DATA_W-1:0]  trace_instr,
   input  logic [DATA_W-1:0]  trace_alu,
   input  logic               arm,
   input  logic               abort,
   input  logic               trig_en,
   input  logic [PC_W-1:0]    trig_pc,
   input  logic               force_trig,
   output logic [1:0]         state,
   output logic [AW:0]        fill,
   output logic               rd_valid,
   input  logic               rd_ready,
   output logic [ENTRY_W-1:0] rd_data
);

   localparam int FW = AW + 1;
   localparam logic [AW:0]   DEPTH_F = FW'(DEPTH);
   localparam logic [AW-1:0] POST_L  = AW'(POST_TRIG);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_POST  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [AW-1:0]       r_wr_ptr;
   logic [AW:0]         r_fill;
   logic [AW-1:0]       r_post_cnt;
   logic [AW-1:0]       r_rd_ptr;
   logic [AW:0]         r_rd_rem;
   logic                r_rd_valid;
   logic [ENTRY_W-1:0]  r_rd_data;
   logic [ENTRY_W-1:0]  r_mem [DEPTH];

   logic [ENTRY_W-1:0]  w_entry;
   logic                w_write;
   logic                w_trig;
   logic                w_post_done;
   logic                w_accept;
   logic                w_drain_end;
   logic [AW-1:0]       w_rd_start;

`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0]     r_ts;

   // Free-running cycle counter; wraps naturally at 2^TS_W
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_ts <= '0;
      else        r_ts <= r_ts + 1'b1;
   end

   assign w_entry = {r_ts, trace_pc, trace_instr, trace_alu};
`else
   assign w_entry = {trace_pc, trace_instr, trace_alu};
`endif

   // A write or trigger coinciding with abort is dropped
   assign w_write     = trace_valid && !abort &&
                        ((r_state == S_ARMED) || (r_state == S_POST));
   assign w_trig      = trace_valid && !abort && (r_state == S_ARMED) &&
                        (force_trig || (trig_en && (trace_pc == trig_pc)));
   assign w_post_done = w_write && (r_state == S_POST) && (r_post_cnt == AW'(1));
   assign w_accept    = (r_state == S_DONE) && r_rd_valid && rd_ready;
   assign w_drain_end = w_accept && (r_rd_rem == FW'(1));
   // Oldest entry: once the buffer has wrapped it sits at the write pointer
   assign w_rd_start  = (r_fill == DEPTH_F) ? r_wr_ptr : '0;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic; abort overrides every other request
   always_comb begin
      w_next = r_state;
      if (abort) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (arm)         w_next = S_ARMED;
            S_ARMED: if (w_trig)      w_next = (POST_TRIG == 0) ? S_DONE : S_POST;
            S_POST:  if (w_post_done) w_next = S_DONE;
            S_DONE:  if (w_drain_end) w_next = S_IDLE;
            default:                  w_next = S_IDLE;
         endcase
      end
   end

   // Capture pointers, fill level, post-trigger count and registered read port
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_fill     <= '0;
         r_post_cnt <= '0;
         r_rd_ptr   <= '0;
         r_rd_rem   <= '0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else if (abort) begin
         r_fill     <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && arm) begin
            r_wr_ptr   <= '0;
            r_fill     <= '0;
            r_post_cnt <= '0;
         end
         if (w_write) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_fill != DEPTH_F) r_fill <= r_fill + 1'b1;
         end
         if (w_trig) begin
            r_post_cnt <= POST_L;
         end else if (w_write && (r_state == S_POST)) begin
            r_post_cnt <= r_post_cnt - 1'b1;
         end
         if (r_state == S_DONE) begin
            if (!r_rd_valid) begin
               // First cycle in DONE: present the oldest entry
               r_rd_data  <= r_mem[w_rd_start];
               r_rd_ptr   <= w_rd_start + 1'b1;
               r_rd_rem   <= r_fill;
               r_rd_valid <= 1'b1;
            end else if (rd_ready) begin
               if (r_rd_rem == FW'(1)) begin
                  r_rd_valid <= 1'b0;
                  r_fill     <= '0;
               end else begin
                  r_rd_data <= r_mem[r_rd_ptr];
                  r_rd_ptr  <= r_rd_ptr + 1'b1;
                  r_rd_rem  <= r_rd_rem - 1'b1;
               end
            end
         end
      end
   end

   // Trace RAM write port; contents are never reset
   always_ff @(posedge clk) begin
      if (w_write) r_mem[r_wr_ptr] <= w_entry;
   end

   assign state    = r_state;
   assign fill     = r_fill;
   assign rd_valid = r_rd_valid;
   assign rd_data  = r_rd_data;

endmodule
